// File: rtl/ber_align_counter.sv
// ber_align_counter: PRBS channel-delay search and locked BER accumulation.
// Optional snapshot registers are built when BER_SNAPSHOT_EN is defined.
module ber_align_counter #(
    parameter int MAX_DELAY  = 1024,
    parameter int PTR_W      = 10,
    parameter int WINDOW     = 511,
    parameter int WIN_W      = 9,
    parameter int LOCK_THR   = 0,
    parameter int UNLOCK_THR = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_valid,
    input  logic             i_data_ref,
    input  logic             i_data_rx,
    input  logic             i_clear,
`ifdef BER_SNAPSHOT_EN
    input  logic             i_snap,
    output logic [CNT_W-1:0] o_snap_bits,
    output logic [CNT_W-1:0] o_snap_errs,
`endif
    output logic             o_locked,
    output logic [PTR_W-1:0] o_delay,
    output logic [CNT_W-1:0] o_bit_count,
    output logic [CNT_W-1:0] o_err_count,
    output logic             o_window_done,
    output logic [7:0]       o_sweeps
);

    typedef enum logic {S_SEARCH, S_LOCKED} state_t;

    localparam int HW = MAX_DELAY - 1;
    localparam logic [WIN_W:0]   LOCK_TOT   = (WIN_W+1)'(LOCK_THR);
    localparam logic [WIN_W:0]   UNLOCK_TOT = (WIN_W+1)'(UNLOCK_THR);
    localparam logic [WIN_W-1:0] LAST_WIN   = WIN_W'(WINDOW - 1);
    localparam logic [PTR_W-1:0] LAST_DLY   = PTR_W'(MAX_DELAY - 1);

    state_t           state_q, state_d;
    logic [HW-1:0]    hist_q, hist_d;
    logic [PTR_W-1:0] delay_q, delay_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [WIN_W-1:0] win_err_q, win_err_d;
    logic [7:0]       sweeps_q, sweeps_d;
    logic [CNT_W-1:0] bits_q, bits_d;
    logic [CNT_W-1:0] errs_q, errs_d;
    logic             wdone_q, wdone_d;
`ifdef BER_SNAPSHOT_EN
    logic [CNT_W-1:0] snap_bits_q, snap_bits_d;
    logic [CNT_W-1:0] snap_errs_q, snap_errs_d;
`endif

    logic                 beat;
    logic                 err;
    logic                 last;
    logic                 wrap;
    logic [MAX_DELAY-1:0] ref_vec;
    logic [WIN_W:0]       total;

    // Reference tap select, error bit and window-end evaluation total.
    always_comb begin
        beat    = i_enable & i_valid;
        ref_vec = {hist_q, i_data_ref};
        err     = i_data_rx ^ ref_vec[delay_q];
        last    = (win_cnt_q == LAST_WIN);
        wrap    = (delay_q == LAST_DLY);
        total   = {1'b0, win_err_q} + {{WIN_W{1'b0}}, err};
    end

    // Next-state: search/lock decisions, window progress and accumulators.
    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        delay_d   = delay_q;
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        sweeps_d  = sweeps_q;
        bits_d    = bits_q;
        errs_d    = errs_q;
        wdone_d   = beat & last;
        if (beat) begin
            hist_d = {hist_q[HW-2:0], i_data_ref};
            if (state_q == S_LOCKED && bits_q != '1) begin
                bits_d = bits_q + 1'b1;
                errs_d = errs_q + {{(CNT_W-1){1'b0}}, err};
            end
            if (last) begin
                win_cnt_d = '0;
                win_err_d = '0;
                if (state_q == S_SEARCH && total <= LOCK_TOT) begin
                    state_d = S_LOCKED;
                end else if (state_q == S_SEARCH || total > UNLOCK_TOT) begin
                    state_d = S_SEARCH;
                    delay_d = wrap ? '0 : delay_q + 1'b1;
                    if (wrap && sweeps_q != 8'hFF) begin
                        sweeps_d = sweeps_q + 1'b1;
                    end
                end
            end else begin
                win_cnt_d = win_cnt_q + 1'b1;
                if (win_err_q != '1) begin
                    win_err_d = win_err_q + {{(WIN_W-1){1'b0}}, err};
                end
            end
        end
        if (i_clear) begin
            bits_d = '0;
            errs_d = '0;
        end
    end

`ifdef BER_SNAPSHOT_EN
    // Snapshot captures the post-update live counters.
    always_comb begin
        snap_bits_d = snap_bits_q;
        snap_errs_d = snap_errs_q;
        if (i_snap) begin
            snap_bits_d = bits_d;
            snap_errs_d = errs_d;
        end
    end
`endif

    // State registers with asynchronous reset.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_SEARCH;
            hist_q      <= '0;
            delay_q     <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            sweeps_q    <= '0;
            bits_q      <= '0;
            errs_q      <= '0;
            wdone_q     <= 1'b0;
`ifdef BER_SNAPSHOT_EN
            snap_bits_q <= '0;
            snap_errs_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            delay_q     <= delay_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            sweeps_q    <= sweeps_d;
            bits_q      <= bits_d;
            errs_q      <= errs_d;
            wdone_q     <= wdone_d;
`ifdef BER_SNAPSHOT_EN
            snap_bits_q <= snap_bits_d;
            snap_errs_q <= snap_errs_d;
`endif
        end
    end

    assign o_locked      = (state_q == S_LOCKED);
    assign o_delay       = delay_q;
    assign o_bit_count   = bits_q;
    assign o_err_count   = errs_q;
    assign o_window_done = wdone_q;
    assign o_sweeps      = sweeps_q;
`ifdef BER_SNAPSHOT_EN
    assign o_snap_bits   = snap_bits_q;
    assign o_snap_errs   = snap_errs_q;
`endif

endmodule

// File: tb/tb_ber_align_counter.sv
// tb_ber_align_counter: randomized PRBS bench with a queue-based reference model.
// Covers search/lock, error density, unlock/resweep, enable, saturation, reset.
module tb_ber_align_counter;

    localparam int MD   = 16;
    localparam int PW   = 4;
    localparam int WIN  = 511;
    localparam int LTHR = 0;
    localparam int UTHR = 16;
    localparam int CW   = 32;
    localparam longint MAXC = (longint'(1) << CW) - 1;
`ifdef BER_SNAPSHOT_EN
    localparam int VW = 2 + PW + 4*CW + 8;
`else
    localparam int VW = 2 + PW + 2*CW + 8;
`endif

    logic          clock;
    logic          i_reset;
    logic          i_enable;
    logic          i_valid;
    logic          i_data_ref;
    logic          i_data_rx;
    logic          i_clear;
    logic          rx8;
    logic          clr8;
    logic          o_locked;
    logic [PW-1:0] o_delay;
    logic [CW-1:0] o_bit_count;
    logic [CW-1:0] o_err_count;
    logic          o_window_done;
    logic [7:0]    o_sweeps;
    logic          u8_locked;
    logic [PW-1:0] u8_delay;
    logic [7:0]    u8_bits;
    logic [7:0]    u8_errs;
    logic          u8_wdone;
    logic [7:0]    u8_sweeps;
`ifdef BER_SNAPSHOT_EN
    logic          i_snap;
    logic [CW-1:0] o_snap_bits;
    logic [CW-1:0] o_snap_errs;
    logic [7:0]    u8_sb;
    logic [7:0]    u8_se;
`endif

    ber_align_counter #(
        .MAX_DELAY(MD), .PTR_W(PW), .WINDOW(WIN), .WIN_W(9),
        .LOCK_THR(LTHR), .UNLOCK_THR(UTHR), .CNT_W(CW)
    ) dut (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable),
        .i_valid(i_valid), .i_data_ref(i_data_ref), .i_data_rx(i_data_rx),
        .i_clear(i_clear),
`ifdef BER_SNAPSHOT_EN
        .i_snap(i_snap), .o_snap_bits(o_snap_bits), .o_snap_errs(o_snap_errs),
`endif
        .o_locked(o_locked), .o_delay(o_delay), .o_bit_count(o_bit_count),
        .o_err_count(o_err_count), .o_window_done(o_window_done),
        .o_sweeps(o_sweeps)
    );

    ber_align_counter #(
        .MAX_DELAY(MD), .PTR_W(PW), .WINDOW(WIN), .WIN_W(9),
        .LOCK_THR(0), .UNLOCK_THR(511), .CNT_W(8)
    ) u8 (
        .clock(clock), .i_reset(i_reset), .i_enable(i_enable),
        .i_valid(i_valid), .i_data_ref(i_data_ref), .i_data_rx(rx8),
        .i_clear(clr8),
`ifdef BER_SNAPSHOT_EN
        .i_snap(1'b0), .o_snap_bits(u8_sb), .o_snap_errs(u8_se),
`endif
        .o_locked(u8_locked), .o_delay(u8_delay), .o_bit_count(u8_bits),
        .o_err_count(u8_errs), .o_window_done(u8_wdone),
        .o_sweeps(u8_sweeps)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vec_n = 0;
    int err_n = 0;

    // Reference model state.
    bit     mq_hist[$];
    bit     m_locked;
    int     m_delay, m_sweeps, m_wcnt, m_werr;
    longint m_bits, m_errs, m_sb, m_se;
    bit     m_wdone;

    // Stimulus state: PRBS9 generator and ideal 5-beat channel.
    bit [8:0] lfsr;
    bit       chan[$];

    task automatic model_reset();
        mq_hist.delete();
        m_locked = 0; m_delay = 0; m_sweeps = 0; m_wcnt = 0; m_werr = 0;
        m_bits = 0; m_errs = 0; m_sb = 0; m_se = 0; m_wdone = 0;
    endtask

    function automatic bit ref_at(int d, bit cur);
        if (d == 0) return cur;
        if (d - 1 < mq_hist.size()) return mq_hist[d-1];
        return 1'b0;
    endfunction

    task automatic advance();
        if (m_delay == MD - 1) begin
            m_delay = 0;
            if (m_sweeps < 255) m_sweeps++;
        end else begin
            m_delay++;
        end
    endtask

    task automatic model_step(input bit en, input bit v, input bit rf,
                              input bit rx, input bit clr, input bit sn);
        bit e;
        int tot;
        bit wd;
        wd = 0;
        if (en && v) begin
            e = rx ^ ref_at(m_delay, rf);
            if (m_locked && m_bits != MAXC) begin
                m_bits++;
                m_errs += e;
            end
            if (m_wcnt == WIN - 1) begin
                wd  = 1;
                tot = m_werr + e;
                if (!m_locked) begin
                    if (tot <= LTHR) m_locked = 1;
                    else advance();
                end else if (tot > UTHR) begin
                    m_locked = 0;
                    advance();
                end
                m_wcnt = 0;
                m_werr = 0;
            end else begin
                m_wcnt++;
                m_werr = (m_werr + e > 511) ? 511 : m_werr + e;
            end
            mq_hist.push_front(rf);
            if (mq_hist.size() > MD - 1) void'(mq_hist.pop_back());
        end
        if (clr) begin
            m_bits = 0;
            m_errs = 0;
        end
        if (sn) begin
            m_sb = m_bits;
            m_se = m_errs;
        end
        m_wdone = wd;
    endtask

    task automatic next_pair(output bit rf, output bit rg);
        bit fb;
        fb   = lfsr[8] ^ lfsr[4];
        lfsr = {lfsr[7:0], fb};
        rf   = fb;
        chan.push_front(rf);
        if (chan.size() > 8) void'(chan.pop_back());
        rg = (chan.size() > 5) ? chan[5] : 1'b0;
    endtask

    function automatic logic [VW-1:0] obs_vec();
`ifdef BER_SNAPSHOT_EN
        return {o_locked, o_delay, o_bit_count, o_err_count, o_window_done,
                o_sweeps, o_snap_bits, o_snap_errs};
`else
        return {o_locked, o_delay, o_bit_count, o_err_count, o_window_done,
                o_sweeps};
`endif
    endfunction

    function automatic logic [VW-1:0] exp_vec();
`ifdef BER_SNAPSHOT_EN
        return {m_locked, PW'(m_delay), CW'(m_bits), CW'(m_errs), m_wdone,
                8'(m_sweeps), CW'(m_sb), CW'(m_se)};
`else
        return {m_locked, PW'(m_delay), CW'(m_bits), CW'(m_errs), m_wdone,
                8'(m_sweeps)};
`endif
    endfunction

    // One clock: drive inputs, clock edge, advance model, settle.
    task automatic tick(input bit en, input bit v, input bit clr,
                        input bit inv, input bit inv8, input bit c8);
        bit rf, rg, sn;
        sn = 0;
        if (en && v) begin
            next_pair(rf, rg);
        end else begin
            rf = 1'($urandom);
            rg = 1'($urandom);
        end
`ifdef BER_SNAPSHOT_EN
        sn = ($urandom_range(0, 7) == 0);
        i_snap = sn;
`endif
        i_enable   = en;
        i_valid    = v;
        i_clear    = clr;
        i_data_ref = rf;
        i_data_rx  = rg ^ inv;
        rx8        = rg ^ inv8;
        clr8       = c8;
        @(posedge clock);
        if (i_reset) model_reset();
        else model_step(en, v, rf, rg ^ inv, clr, sn);
        #1;
    endtask

    task automatic test_reset();
        i_reset = 1;
        #3;
        vec_n++;
        if (obs_vec() !== '0) begin
            err_n++;
            $display("FAIL reset_main got %h want 0", obs_vec());
        end
        vec_n++;
        if ({u8_locked, u8_delay, u8_bits, u8_errs, u8_wdone, u8_sweeps} !== '0) begin
            err_n++;
            $display("FAIL reset_u8 got %h want 0",
                     {u8_locked, u8_delay, u8_bits, u8_errs, u8_wdone, u8_sweeps});
        end
        @(posedge clock);
        #1;
        i_reset = 0;
        model_reset();
    endtask

    task automatic test_lock_search();
        int lock_at;
        lock_at = -1;
        for (int n = 0; n < 4000 && lock_at < 0; n++) begin
            tick(1, 1, 0, 0, 0, 0);
            vec_n++;
            if (obs_vec() !== exp_vec()) begin
                err_n++;
                $display("FAIL lock_model beat %0d got %h want %h", n, obs_vec(), exp_vec());
            end
            if (o_locked === 1'b1) lock_at = n;
        end
        vec_n++;
        if (lock_at != 3065) begin
            err_n++;
            $display("FAIL lock_beat got %0d want 3065", lock_at);
        end
        vec_n++;
        if (o_delay !== PW'(5) || o_sweeps !== 8'd0) begin
            err_n++;
            $display("FAIL lock_delay got %0d/%0d want 5/0", o_delay, o_sweeps);
        end
        vec_n++;
        if (u8_locked !== 1'b1) begin
            err_n++;
            $display("FAIL lock_u8 got %b want 1", u8_locked);
        end
    endtask

    task automatic test_err_density();
        int pulses, pos;
        pulses = 0;
        for (int b = 0; b < 100; b++) begin
            pos = $urandom_range(0, 99);
            for (int k = 0; k < 100; k++) begin
                tick(1, 1, 0, (k == pos), 0, 0);
                vec_n++;
                if (obs_vec() !== exp_vec()) begin
                    err_n++;
                    $display("FAIL density_model blk %0d got %h want %h", b, obs_vec(), exp_vec());
                end
                if (o_window_done === 1'b1) pulses++;
            end
        end
        vec_n++;
        if (o_bit_count !== 32'd10000 || o_err_count !== 32'd100 || o_locked !== 1'b1) begin
            err_n++;
            $display("FAIL density_counts got %0d/%0d/%b want 10000/100/1",
                     o_bit_count, o_err_count, o_locked);
        end
        vec_n++;
        if (pulses != 19) begin
            err_n++;
            $display("FAIL density_pulses got %0d want 19", pulses);
        end
    endtask

    task automatic test_unlock();
        logic [CW-1:0] b0, e0;
        int guard;
        guard = 0;
        while (m_wcnt != 0 && guard < 600) begin
            tick(1, 1, 0, 0, 0, 0);
            guard++;
        end
        b0 = o_bit_count;
        e0 = o_err_count;
        for (int k = 0; k < WIN; k++) begin
            tick(1, 1, 0, 1, 0, 0);
            vec_n++;
            if (obs_vec() !== exp_vec()) begin
                err_n++;
                $display("FAIL unlock_model beat %0d got %h want %h", k, obs_vec(), exp_vec());
            end
        end
        vec_n++;
        if (o_locked !== 1'b0 || o_delay !== PW'(6) ||
            o_bit_count !== b0 + 511 || o_err_count !== e0 + 511) begin
            err_n++;
            $display("FAIL unlock_state got %b/%0d/%0d/%0d want 0/6/%0d/%0d",
                     o_locked, o_delay, o_bit_count, o_err_count, b0 + 511, e0 + 511);
        end
        guard = 0;
        while (o_locked !== 1'b1 && guard < 25 * WIN) begin
            tick(1, 1, 0, 0, 0, 0);
            guard++;
            vec_n++;
            if (obs_vec() !== exp_vec()) begin
                err_n++;
                $display("FAIL resweep_model beat %0d got %h want %h", guard, obs_vec(), exp_vec());
            end
        end
        vec_n++;
        if (o_locked !== 1'b1 || o_delay !== PW'(5) || o_sweeps !== 8'd1 ||
            o_bit_count !== b0 + 511) begin
            err_n++;
            $display("FAIL relock got %b/%0d/%0d/%0d want 1/5/1/%0d",
                     o_locked, o_delay, o_sweeps, o_bit_count, b0 + 511);
        end
    endtask

    task automatic test_valid_toggle();
        logic [CW-1:0] b0;
        logic [VW-1:0] held;
        b0 = o_bit_count;
        for (int c = 0; c < 2000; c++) begin
            tick(1, (c % 2 == 0), 0, 0, 0, 0);
            vec_n++;
            if (obs_vec() !== exp_vec()) begin
                err_n++;
                $display("FAIL toggle_model cyc %0d got %h want %h", c, obs_vec(), exp_vec());
            end
        end
        vec_n++;
        if (o_bit_count !== b0 + 1000 || o_locked !== 1'b1) begin
            err_n++;
            $display("FAIL toggle_bits got %0d/%b want %0d/1", o_bit_count, o_locked, b0 + 1000);
        end
        tick(1, 0, 0, 0, 0, 0);
        held = obs_vec();
        for (int c = 0; c < 50; c++) begin
            tick(0, 1'($urandom), 0, 1'($urandom), 0, 0);
            vec_n++;
`ifdef BER_SNAPSHOT_EN
            if (obs_vec() !== exp_vec()) begin
`else
            if (obs_vec() !== held || obs_vec() !== exp_vec()) begin
`endif
                err_n++;
                $display("FAIL enable_freeze cyc %0d got %h want %h", c, obs_vec(), held);
            end
        end
    endtask

    task automatic test_saturate();
        tick(1, 1, 1, 0, 0, 1);
        vec_n++;
        if (u8_bits !== 8'd0 || u8_errs !== 8'd0 || o_bit_count !== 32'd0) begin
            err_n++;
            $display("FAIL clear_first got %0d/%0d/%0d want 0/0/0", u8_bits, u8_errs, o_bit_count);
        end
        for (int k = 0; k < 300; k++) begin
            tick(1, 1, 0, 0, 1, 0);
            vec_n++;
            if (obs_vec() !== exp_vec()) begin
                err_n++;
                $display("FAIL sat_model beat %0d got %h want %h", k, obs_vec(), exp_vec());
            end
        end
        vec_n++;
        if (u8_bits !== 8'd255 || u8_errs !== 8'd255 || u8_locked !== 1'b1) begin
            err_n++;
            $display("FAIL sat_freeze got %0d/%0d/%b want 255/255/1", u8_bits, u8_errs, u8_locked);
        end
        tick(1, 1, 0, 0, 1, 1);
        vec_n++;
        if (u8_bits !== 8'd0 || u8_errs !== 8'd0) begin
            err_n++;
            $display("FAIL sat_clear got %0d/%0d want 0/0", u8_bits, u8_errs);
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 100; k++) tick(1, 1, 0, 0, 0, 0);
        #3;
        i_reset = 1;
        #1;
        vec_n++;
        if (obs_vec() !== '0 || u8_locked !== 1'b0 || u8_bits !== 8'd0) begin
            err_n++;
            $display("FAIL async_reset got %h want 0", obs_vec());
        end
        model_reset();
        @(posedge clock);
        #1;
        i_reset = 0;
        test_lock_search();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1; i_enable = 0; i_valid = 0; i_clear = 0;
        i_data_ref = 0; i_data_rx = 0; rx8 = 0; clr8 = 0;
`ifdef BER_SNAPSHOT_EN
        i_snap = 0;
`endif
        lfsr = 9'($urandom_range(1, 511));
        model_reset();
        test_reset();
        test_lock_search();
        test_err_density();
        test_unlock();
        test_valid_toggle();
        test_saturate();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
        $finish;
    end

endmodule
